// File: rtl/packet_assembler.sv
// Packs a validated byte stream into 48-bit {app,size,packet,data} words, MSB byte first.
// Optional packet-order checking is compiled in with `define ASM_SEQ_CHECK_EN.
module packet_assembler #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [47:0]      dataout,
  output logic             word_valid,
  output logic             hdr_err,
  output logic             to_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t             state, state_next;
  logic [39:0]        shift_reg, shift_next;
  logic [2:0]         byte_cnt, byte_cnt_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [47:0]        dataout_next;
  logic               word_valid_next, hdr_err_next, to_err_next, seq_err_next;
  logic               in_ready_next;
  logic [CNT_W-1:0]   word_cnt_next;

  logic               accept;
  logic [1:0]         hdr_app;
  logic [2:0]         hdr_size, hdr_pkt;
  logic               hdr_legal;
  logic               seq_drop, seq_restart;

  assign accept   = in_valid & in_ready;
  assign hdr_app  = in_data[7:6];
  assign hdr_size = in_data[5:3];
  assign hdr_pkt  = in_data[2:0];

  assign hdr_legal = ((hdr_app == 2'b01) || (hdr_app == 2'b10)) &&
                     (((hdr_size == 3'b001) && (hdr_pkt == 3'b000)) ||
                      (((hdr_size == 3'b010) || (hdr_size == 3'b011)) &&
                       ((hdr_pkt == 3'b001) || (hdr_pkt == 3'b010))));

`ifdef ASM_SEQ_CHECK_EN
  logic       pending;
  logic [1:0] pend_app;
  logic [2:0] pend_size;
  logic       emit_now;

  assign emit_now    = (state == COLLECT) && accept && (byte_cnt == 3'd5);
  assign seq_drop    = (hdr_pkt == 3'b010) &&
                       (!pending || (pend_app != hdr_app) || (pend_size != hdr_size));
  assign seq_restart = (hdr_pkt != 3'b010) && pending;

  // The first word of a two-part packet arms the tracker; shift_reg[39:32] is its header.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending   <= 1'b0;
      pend_app  <= 2'b00;
      pend_size <= 3'b000;
    end else if (emit_now && (shift_reg[34:32] == 3'b001)) begin
      pending   <= 1'b1;
      pend_app  <= shift_reg[39:38];
      pend_size <= shift_reg[37:35];
    end else if (emit_now && (shift_reg[34:32] == 3'b010)) begin
      pending <= 1'b0;
    end else if ((state == IDLE) && accept && hdr_legal && seq_restart) begin
      pending <= 1'b0;
    end
  end
`else
  assign seq_drop    = 1'b0;
  assign seq_restart = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    shift_next      = shift_reg;
    byte_cnt_next   = byte_cnt;
    timer_next      = timer;
    dataout_next    = '0;
    word_valid_next = 1'b0;
    hdr_err_next    = 1'b0;
    to_err_next     = 1'b0;
    seq_err_next    = 1'b0;
    word_cnt_next   = word_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!hdr_legal) begin
            hdr_err_next = 1'b1;
          end else if (seq_drop) begin
            seq_err_next = 1'b1;
          end else begin
            seq_err_next  = seq_restart;
            shift_next    = {32'd0, in_data};
            byte_cnt_next = 3'd1;
            timer_next    = '0;
            state_next    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          timer_next = '0;
          if (byte_cnt == 3'd5) begin
            dataout_next    = {shift_reg, in_data};
            word_valid_next = 1'b1;
            word_cnt_next   = word_cnt + CNT_W'(1);
            byte_cnt_next   = 3'd0;
            state_next      = EMIT;
          end else begin
            shift_next    = {shift_reg[31:0], in_data};
            byte_cnt_next = byte_cnt + 3'd1;
          end
        end else if (timer == TMR_LAST) begin
          // Stalled partial word is abandoned; a byte on this same cycle would have won.
          to_err_next   = 1'b1;
          timer_next    = '0;
          byte_cnt_next = 3'd0;
          shift_next    = '0;
          state_next    = IDLE;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      EMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    in_ready_next = (state_next != EMIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shift_reg  <= '0;
      byte_cnt   <= 3'd0;
      timer      <= '0;
      dataout    <= '0;
      word_valid <= 1'b0;
      hdr_err    <= 1'b0;
      to_err     <= 1'b0;
      seq_err    <= 1'b0;
      word_cnt   <= '0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      byte_cnt   <= byte_cnt_next;
      timer      <= timer_next;
      dataout    <= dataout_next;
      word_valid <= word_valid_next;
      hdr_err    <= hdr_err_next;
      to_err     <= to_err_next;
      seq_err    <= seq_err_next;
      word_cnt   <= word_cnt_next;
      in_ready   <= in_ready_next;
    end
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: expected words are queued as bytes are sent and
// checked when word_valid fires; each scenario task checks its own pulses and timing.
module tb_packet_assembler;

  localparam int T     = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rstn;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      dataout;
  logic             word_valid;
  logic             hdr_err;
  logic             to_err;
  logic             seq_err;
  logic [CNT_W-1:0] word_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int wv_cnt = 0, hdr_cnt = 0, to_cnt = 0, seq_cnt = 0;
  logic [47:0] exp_q[$];

  packet_assembler #(.TIMEOUT_CYC(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dataout(dataout), .word_valid(word_valid), .hdr_err(hdr_err), .to_err(to_err),
    .seq_err(seq_err), .word_cnt(word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: scoreboard pops, idle-zero check, pulse exclusivity and pulse counting.
  always @(negedge clk) begin
    if (rstn) begin
      vectors++;
      if (word_valid) begin
        wv_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_word: got %h, none expected", dataout);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if (dataout !== e) begin
            miscompares++;
            $display("[TB] FAIL word_data: got %h expected %h", dataout, e);
          end
        end
        vectors++;
        if ((hdr_err | to_err | seq_err) !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL pulse_overlap: errs=%b%b%b expected 000", hdr_err, to_err, seq_err);
        end
      end else if (dataout !== 48'd0) begin
        miscompares++;
        $display("[TB] FAIL idle_dataout: got %h expected 0", dataout);
      end
      if (hdr_err) hdr_cnt++;
      if (to_err)  to_cnt++;
      if (seq_err) seq_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic took;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    while (!took && n < 10) begin
      took = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!took) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_byte_stall: byte %h not accepted in %0d cycles", b, n);
    end
  endtask

  task automatic send_word(input logic [47:0] w);
    exp_q.push_back(w);
    for (int i = 5; i >= 0; i--) send_byte(w[i*8 +: 8]);
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (wv_cnt < target && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vectors++;
    if (wv_cnt != target) begin
      miscompares++;
      $display("[TB] FAIL word_count_wait: got %0d expected %0d", wv_cnt, target);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, word_valid, hdr_err, to_err, seq_err} !== 5'b0 || dataout !== 48'd0 ||
        word_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: rdy=%b wv=%b do=%h cnt=%0d expected all 0",
               in_ready, word_valid, dataout, word_cnt);
    end
    rstn = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_at_release: got %b expected 0", in_ready);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_release: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic_word();
    exp_q.push_back(48'h48_1122334455);
    send_byte(8'h48); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    in_valid = 1'b0;
    vectors++;
    if (word_valid !== 1'b1 || dataout !== 48'h48_1122334455 || word_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: wv=%b do=%h cnt=%0d expected 1 481122334455 1",
               word_valid, dataout, word_cnt);
    end
    @(negedge clk);
    vectors++;
    if (word_valid !== 1'b0 || dataout !== 48'd0) begin
      miscompares++;
      $display("[TB] FAIL basic_after: wv=%b do=%h expected 0 0", word_valid, dataout);
    end
  endtask

  task automatic test_bad_header();
    int h0, w0;
    h0 = hdr_cnt;
    w0 = wv_cnt;
    send_byte(8'hC8);
    in_valid = 1'b0;
    vectors++;
    if (hdr_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hdr_err_pulse: got %b expected 1", hdr_err);
    end
    send_word(48'h48_6677889900);
    wait_words(w0 + 1);
    vectors++;
    if (hdr_cnt - h0 != 1) begin
      miscompares++;
      $display("[TB] FAIL hdr_err_count: got %0d expected 1", hdr_cnt - h0);
    end
  endtask

  task automatic test_timeout();
    int t0, w0;
    t0 = to_cnt;
    w0 = wv_cnt;
    send_byte(8'h91); send_byte(8'h01); send_byte(8'h02);
    in_valid = 1'b0;
    for (int i = 1; i < T; i++) begin
      @(negedge clk);
      vectors++;
      if (to_err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL timeout_early: cycle %0d got %b expected 0", i, to_err);
      end
    end
    @(negedge clk);
    vectors++;
    if (to_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_pulse: got %b expected 1", to_err);
    end
    @(negedge clk);
    vectors++;
    if (to_err !== 1'b0 || wv_cnt != w0) begin
      miscompares++;
      $display("[TB] FAIL timeout_after: to_err=%b words=%0d expected 0 %0d", to_err, wv_cnt, w0);
    end
    exp_q.push_back(48'h48_0102030405);
    send_byte(8'h48); send_byte(8'h01); send_byte(8'h02);
    in_valid = 1'b0;
    repeat (T - 1) @(negedge clk);
    send_byte(8'h03);
    vectors++;
    if (to_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_limit_byte: got %b expected 0", to_err);
    end
    send_byte(8'h04); send_byte(8'h05);
    in_valid = 1'b0;
    wait_words(w0 + 1);
    vectors++;
    if (to_cnt - t0 != 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_count: got %0d expected 1", to_cnt - t0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [12];
    int idx, cyc, w0;
    logic [47:0] wa, wb;
    wa = 48'h48_A1A2A3A4A5;
    wb = 48'h88_B1B2B3B4B5;
    for (int i = 0; i < 6; i++) begin
      bytes[i]     = wa[(5-i)*8 +: 8];
      bytes[i + 6] = wb[(5-i)*8 +: 8];
    end
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    w0 = wv_cnt;
    idx = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (idx < 12 && cyc < 40) begin
      in_data = bytes[idx];
      vectors++;
      if (in_ready !== ~word_valid) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready: cycle %0d rdy=%b wv=%b expected rdy=~wv", cyc, in_ready, word_valid);
      end
      if (in_ready) idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cyc != 13) begin
      miscompares++;
      $display("[TB] FAIL b2b_cycles: got %0d expected 13", cyc);
    end
    wait_words(w0 + 2);
  endtask

`ifdef ASM_SEQ_CHECK_EN
  task automatic test_seq_check();
    int s0, h0, w0;
    s0 = seq_cnt;
    h0 = hdr_cnt;
    w0 = wv_cnt;
    send_byte(8'h92);
    in_valid = 1'b0;
    vectors++;
    if (seq_err !== 1'b1 || hdr_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL seq_orphan: seq=%b hdr=%b expected 1 0", seq_err, hdr_err);
    end
    send_word(48'h91_C1C2C3C4C5);
    send_word(48'h92_D1D2D3D4D5);
    wait_words(w0 + 2);
    vectors++;
    if (seq_cnt - s0 != 1) begin
      miscompares++;
      $display("[TB] FAIL seq_pair: got %0d pulses expected 1", seq_cnt - s0);
    end
    send_word(48'h91_E1E2E3E4E5);
    send_word(48'h91_F1F2F3F4F5);
    send_word(48'h92_0A0B0C0D0E);
    wait_words(w0 + 5);
    vectors++;
    if (seq_cnt - s0 != 2 || hdr_cnt != h0) begin
      miscompares++;
      $display("[TB] FAIL seq_restart: seq=%0d hdr=%0d expected 2 0", seq_cnt - s0, hdr_cnt - h0);
    end
  endtask
`else
  task automatic test_seq_disabled();
    int s0, w0;
    s0 = seq_cnt;
    w0 = wv_cnt;
    send_word(48'h92_D1D2D3D4D5);
    wait_words(w0 + 1);
    vectors++;
    if (seq_cnt != s0) begin
      miscompares++;
      $display("[TB] FAIL seq_disabled: got %0d pulses expected 0", seq_cnt - s0);
    end
  endtask
`endif

  task automatic test_reset_mid_word();
    int h0, t0, s0, w0, exp_cnt;
    send_byte(8'h48); send_byte(8'h01); send_byte(8'h02);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    vectors++;
    if (word_cnt !== '0 || in_ready !== 1'b0 || dataout !== 48'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: cnt=%0d rdy=%b do=%h expected 0 0 0",
               word_cnt, in_ready, dataout);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    h0 = hdr_cnt;
    t0 = to_cnt;
    s0 = seq_cnt;
    w0 = wv_cnt;
    exp_cnt = 1;
`ifdef ASM_SEQ_CHECK_EN
    send_word(48'h59_0102030405);
    exp_cnt = 2;
`endif
    send_word(48'h5A_AABBCCDDEE);
    wait_words(w0 + exp_cnt);
    vectors++;
    if (hdr_cnt != h0 || to_cnt != t0 || seq_cnt != s0 || word_cnt !== CNT_W'(exp_cnt)) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover: hdr=%0d to=%0d seq=%0d cnt=%0d expected 0 0 0 %0d",
               hdr_cnt - h0, to_cnt - t0, seq_cnt - s0, word_cnt, exp_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_word();
    test_bad_header();
    test_timeout();
    test_back_to_back();
`ifdef ASM_SEQ_CHECK_EN
    test_seq_check();
`else
    test_seq_disabled();
`endif
    test_reset_mid_word();
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL words_outstanding: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
